step_conditioner: RTL and testbench

Upstream conditioning stage for the lab sequence-detector FSM. It takes the raw active-low pushbutton and the raw `w` slide switch, synchronises both to the board clock, and debounces the button. It emits exactly one single-cycle `step` pulse per clean press, together with a `w_out` value captured at that instant. The detector then advances on `step` as a clock enable, instead of using the button as a clock.

---
 rtl/step_conditioner.sv | 85 ++++++++
 tb/tb_step_conditioner.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/step_conditioner.sv
// step_conditioner: synchronise and debounce a pushbutton into one-cycle step pulses with a captured w bit
// Ports:
//   clock, reset      board clock, asynchronous active-high reset
//   key_n, w_raw      raw active-low pushbutton and raw w switch (asynchronous)
//   step              one-cycle pulse per accepted press
//   w_out             synchronised w captured when step rises, held until the next step
//   step_count        accepted presses modulo 256
//   db_state          debounce state: 0 idle, 1 press wait, 2 pressed, 3 release wait
module step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  input  logic       w_raw,
  output logic       step,
  output logic       w_out,
  output logic [7:0] step_count,
  output logic [1:0] db_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, PRESS_WAIT = 2'd1, PRESSED = 2'd2, RELEASE_WAIT = 2'd3} state_t;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic key_meta_q, key_s_q, w_meta_q, w_s_q;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic step_q, step_d, w_out_q, w_out_d;
  logic [7:0] count_q, count_d;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
      w_meta_q   <= 1'b0;
      w_s_q      <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      w_out_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      key_meta_q <= key_n;
      key_s_q    <= key_meta_q;
      w_meta_q   <= w_raw;
      w_s_q      <= w_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      w_out_q    <= w_out_d;
      count_q    <= count_d;
    end
  end
  // Each wait state counts consecutive agreeing samples; one disagreeing sample falls back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    w_out_d = w_out_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (!key_s_q) begin
        state_d = PRESS_WAIT;
        cnt_d   = '0;
      end
      PRESS_WAIT: if (key_s_q) state_d = IDLE;
        else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          step_d  = 1'b1;
          w_out_d = w_s_q;
          count_d = count_q + 8'd1;
        end else cnt_d = cnt_q + CNT_W'(1);
      PRESSED: if (key_s_q) begin
        state_d = RELEASE_WAIT;
        cnt_d   = '0;
      end
      RELEASE_WAIT: if (!key_s_q) state_d = PRESSED;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end
  assign step       = step_q;
  assign w_out      = w_out_q;
  assign step_count = count_q;
  assign db_state   = state_q;
endmodule

// File: tb/tb_step_conditioner.sv
// tb_step_conditioner: randomized scoreboard bench for step_conditioner with a run-length reference model
module tb_step_conditioner;
  localparam int N = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic key_n = 1'b0;
  logic w_raw = 1'b1;
  logic step, w_out;
  logic [7:0] step_count;
  logic [1:0] db_state;
  step_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .key_n(key_n), .w_raw(w_raw),
    .step(step), .w_out(w_out), .step_count(step_count), .db_state(db_state)
  );
  always #5 clock = ~clock;
  typedef struct {logic w; logic [7:0] c;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int dut_pulses = 0;
  int model_pulses = 0;
  logic k1 = 1'b1, k2 = 1'b1, w1 = 1'b0, w2 = 1'b0;
  logic lvl = 1'b0;
  int run = 0;
  logic e_step = 1'b0, e_w = 1'b0;
  logic [7:0] e_cnt = 8'd0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: the accepted level flips after N+1 consecutive synchronised samples disagreeing with it.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      k1 = 1'b1; k2 = 1'b1; w1 = 1'b0; w2 = 1'b0;
      lvl = 1'b0; run = 0; e_step = 1'b0; e_w = 1'b0; e_cnt = 8'd0;
      sb.delete();
    end else begin
      logic ks, ws;
      ks = k2; ws = w2;
      k2 = k1; k1 = key_n;
      w2 = w1; w1 = w_raw;
      e_step = 1'b0;
      if ((ks == 1'b0) != lvl) begin
        run++;
        if (run == N + 1) begin
          lvl = ~lvl;
          run = 0;
          if (lvl) begin
            e_step = 1'b1;
            e_w = ws;
            e_cnt = e_cnt + 8'd1;
            model_pulses++;
            sb.push_back('{w: ws, c: e_cnt});
          end
        end
      end else run = 0;
    end
  end
  always @(negedge clock) begin
    chk("step", int'(step), int'(e_step));
    chk("w_out", int'(w_out), int'(e_w));
    chk("step_count", int'(step_count), int'(e_cnt));
    chk("db_state", int'(db_state), lvl ? (run != 0 ? 3 : 2) : (run != 0 ? 1 : 0));
    if (step === 1'b1) begin
      dut_pulses++;
      if (sb.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_w_out", int'(w_out), int'(e.w));
        chk("sb_step_count", int'(step_count), int'(e.c));
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask
  task automatic press(input logic w, input int low, input int high);
    w_raw = w;
    key_n = 1'b0;
    tick(low);
    key_n = 1'b1;
    w_raw = 1'($urandom);
    tick(high);
  endtask
  initial begin
    int p0;
    logic [6:0] pat;
    tick(3);
    key_n = 1'b1;
    w_raw = 1'b0;
    reset = 1'b0;
    tick(3);
    press(1'b1, 20, 12);
    chk("clean_press_count", int'(step_count), 1);
    key_n = 1'b0; tick(2);
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(3);
    key_n = 1'b1; tick(1);
    chk("bounce_no_pulse", int'(step_count), 1);
    key_n = 1'b0; tick(10);
    key_n = 1'b1; tick(12);
    key_n = 1'b0; tick(12);
    key_n = 1'b1; tick(2);
    key_n = 1'b0; tick(1);
    key_n = 1'b1; tick(12);
    chk("release_bounce_count", int'(step_count), 3);
    pat = 7'b1111011;
    for (int i = 0; i < 7; i++) press(pat[i], 8, 8);
    chk("sequence_count", int'(step_count), 10);
    for (int i = 0; i < 300; i++) begin
      key_n = 1'($urandom);
      w_raw = 1'($urandom);
      tick($urandom_range(1, 8));
    end
    key_n = 1'b1;
    tick(12);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) press(1'($urandom), 7, 7);
    chk("wrap_count", int'(step_count), 0);
    p0 = dut_pulses;
    key_n = 1'b0;
    tick(4);
    chk("in_press_wait", int'(db_state), 1);
    reset = 1'b1;
    tick(2);
    chk("reset_mid_press_count", int'(step_count), 0);
    reset = 1'b0;
    tick(12);
    key_n = 1'b1;
    tick(12);
    chk("post_reset_pulses", dut_pulses - p0, 1);
    chk("post_reset_count", int'(step_count), 1);
    chk("sb_empty", sb.size(), 0);
    chk("pulse_total", dut_pulses, model_pulses);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
